io_input_controller: RTL and testbench
======================================

Name: io_input_controller

Overview:
- Sequences the processor's I/O path for IN/OUT instructions.
- On an input request it stalls the CPU and waits for a debounced press-and-release of the active-low confirm button. On the press it captures the switch bank, then releases the stall with a one-cycle valid pulse.
- On an output request it loads the display output register.
- Sits between the control unit (stall, request strobes) and the board pins (switches, confirm button).

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples needed to accept a button level change.
- TIMEOUT_CYCLES, 1000: cycles spent in WAIT_PRESS before timeout (used only with the optional feature).

Ports:
- Clock  in  1: system clock; all state on rising edge.
- Reset  in  1: asynchronous, active-high reset.
- IORead  in  1: CPU requests an input value; held until Stall drops.
- IOWrite  in  1: CPU writes an output value; sampled in IDLE only.
- WriteData  in  32: value for IOWrite.
- Switches  in  13: board switch bank (quasi-static).
- SetN  in  1: confirm push button, active-low, asynchronous to Clock.
- Stall  out  1: freezes the CPU PC/pipeline while high.
- ReadData  out  32: captured input, Switches zero-extended to 32 bits.
- ReadValid  out  1: one-cycle pulse, ReadData is valid for the CPU.
- Output  out  32: display output register.
- OutputValid  out  1: sticky, set by the first IOWrite after reset.
- Waiting  out  1: high in WAIT_PRESS (drives the "enter value" LED).
- TimedOut  out  1: one-cycle pulse on timeout; constant 0 when the feature is compiled out.

Behaviour:
- Reset values:
  - state = IDLE.
  - Output, ReadData = 0.
  - ReadValid, OutputValid, TimedOut = 0.
  - Synchronizer flops = 1 (button released); debounced Pressed = 0; debounce and timeout counters = 0.
  - Stall is forced to 0 while Reset is high.
- Button path:
  - SetN passes through a 2-flop synchronizer and is inverted to form a raw press level.
  - The counter increments each cycle the raw level differs from Pressed. It clears on any cycle the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES, Pressed toggles and the counter clears.
  - PressEdge and ReleaseEdge are registered 0->1 and 1->0 transitions of Pressed.
- Stall = (state==IDLE && IORead) | (state==WAIT_PRESS) | (state==WAIT_RELEASE). This is combinational, so the CPU freezes in the same cycle the request appears.
- FSM:
  - IDLE:
    - IORead=1 -> WAIT_PRESS.
    - IOWrite=1 -> Output <= WriteData, OutputValid <= 1.
    - Both requests together: the write completes and the read starts.
  - WAIT_PRESS:
    - PressEdge -> ReadData <= {19'b0, Switches} sampled on that edge; go to WAIT_RELEASE.
    - Pressed being already 1 on entry (button held from before) does not count. A release and a fresh press are required.
  - WAIT_RELEASE: ReleaseEdge -> DONE.
  - DONE:
    - Stall=0 and ReadValid=1 for exactly one cycle.
    - Next state is IDLE unconditionally, even if IORead is still high. The CPU has advanced on this edge.
- IOWrite outside IDLE is ignored. ReadData holds its value until the next capture.
- Reset in any state returns to IDLE within the same cycle (asynchronous). Any partial capture is discarded and ReadData = 0.
- No latency bound on button wait when the optional feature is off. Minimum request-to-ReadValid time is 2 synchronizer cycles + 2×DEBOUNCE_CYCLES + edge and state cycles.

Optional Feature:
- Macro IO_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to WAIT_PRESS and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES with no PressEdge: ReadData <= 0, TimedOut pulses for 1 cycle, go to DONE.
  - PressEdge in the same cycle as the timeout wins (normal capture).
- Undefined: no counter; TimedOut tied to 0; WAIT_PRESS waits indefinitely.

Test Plan:
- Capture: Switches=13'h1A5, IORead=1, SetN low 10 cycles then high 10 cycles -> Stall high from the request cycle until DONE; ReadData=32'h000001A5; ReadValid high exactly 1 cycle; Stall low in DONE.
- Glitch: in WAIT_PRESS (DEBOUNCE_CYCLES=4), SetN low for 2 cycles then high -> Pressed stays 0; state stays WAIT_PRESS; Waiting=1; ReadValid never pulses.
- Held button: SetN low before IORead, kept low 20 cycles, then released and pressed again with Switches=13'h0007 -> capture occurs only after the fresh press; ReadData=32'h00000007.
- Output: IOWrite=1, WriteData=32'hDEADBEEF in IDLE -> next edge Output=32'hDEADBEEF, OutputValid=1. IOWrite with 32'h1 during WAIT_PRESS -> Output unchanged.
- Reset mid-op: Reset pulsed in WAIT_RELEASE after a capture of 13'h1FFF -> Stall=0, ReadData=0, state IDLE, no ReadValid pulse.
- Timeout (IO_TIMEOUT_EN, TIMEOUT_CYCLES=20): IORead with no button activity -> after 20 cycles in WAIT_PRESS, TimedOut and ReadValid pulse together; ReadData=0; Stall drops.

Source files
------------

// File: rtl/io_input_controller.sv
// Purpose : I/O sequencer for IN/OUT instructions; stalls the CPU on IN until a debounced
//           press/release of the confirm button, captures the switch bank on the press.
// Latency : OUT updates Output on the next edge; IN completes at the earliest after
//           2 sync + 2*DEBOUNCE_CYCLES + edge/state cycles after the request (ReadValid pulse).
// Backpressure: Stall is held high combinationally from the request cycle until DONE,
//           where it drops for exactly one cycle together with the ReadValid pulse.
//
// Ports:
//   Clock, Reset          - system clock, asynchronous active-high reset
//   IORead, IOWrite       - CPU request strobes (IORead held until Stall drops)
//   WriteData[31:0]       - value for the display register on IOWrite
//   Switches[12:0], SetN  - board switch bank and active-low confirm button (async)
//   Stall                 - freezes the CPU while high
//   ReadData[31:0]        - captured switches, zero-extended; ReadValid one-cycle strobe
//   Output[31:0]          - display register; OutputValid sticky after first write
//   Waiting               - high while waiting for the press (LED)
//   TimedOut              - one-cycle pulse on timeout (tied 0 unless IO_TIMEOUT_EN)
//
// Optional feature macro: IO_TIMEOUT_EN (abandons WAIT_PRESS after TIMEOUT_CYCLES cycles).

module io_input_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [31:0] WriteData,
    input  logic [12:0] Switches,
    input  logic        SetN,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic [31:0] Output,
    output logic        OutputValid,
    output logic        Waiting,
    output logic        TimedOut
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_DONE         = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Button path: 2-flop synchronizer, debounce counter, edge detectors
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic            raw_press;
    logic            pressed_q, pressed_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_edge_q, press_edge_d;
    logic            release_edge_q, release_edge_d;

    assign raw_press = ~sync2_q;

    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        // Any sample agreeing with the accepted level restarts the count,
        // so only DEBOUNCE_CYCLES consecutive disagreeing samples toggle it.
        if (raw_press != pressed_q) begin
            if (db_cnt_q == DB_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_edge_d   =  pressed_d & ~pressed_q;
        release_edge_d = ~pressed_d &  pressed_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            pressed_q      <= 1'b0;
            db_cnt_q       <= '0;
            press_edge_q   <= 1'b0;
            release_edge_q <= 1'b0;
        end else begin
            sync1_q        <= SetN;
            sync2_q        <= sync1_q;
            pressed_q      <= pressed_d;
            db_cnt_q       <= db_cnt_d;
            press_edge_q   <= press_edge_d;
            release_edge_q <= release_edge_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT_PRESS timeout
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   timeout_hit;

`ifdef IO_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timed_out_q, timed_out_d;

    always_comb begin
        // Held at zero outside WAIT_PRESS, so it starts from 0 on every entry.
        tmo_cnt_d   = (state_q == S_WAIT_PRESS) ? tmo_cnt_q + 32'd1 : 32'd0;
        timeout_hit = (state_q == S_WAIT_PRESS) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
        // A press edge arriving in the timeout cycle takes priority.
        timed_out_d = timeout_hit && !press_edge_q;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tmo_cnt_q   <= 32'd0;
            timed_out_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign TimedOut = timed_out_q;
`else
    assign timeout_hit = 1'b0;
    assign TimedOut    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic [31:0] output_q, output_d;
    logic        output_valid_q, output_valid_d;

    always_comb begin
        state_d        = state_q;
        read_data_d    = read_data_q;
        read_valid_d   = 1'b0;
        output_d       = output_q;
        output_valid_d = output_valid_q;

        case (state_q)
            S_IDLE: begin
                // A simultaneous read and write are both honoured.
                if (IOWrite) begin
                    output_d       = WriteData;
                    output_valid_d = 1'b1;
                end
                if (IORead) begin
                    state_d = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                // Only a fresh 0->1 edge counts; a button already held on entry
                // produced its edge earlier and is ignored.
                if (press_edge_q) begin
                    read_data_d = {19'b0, Switches};
                    state_d     = S_WAIT_RELEASE;
                end else if (timeout_hit) begin
                    read_data_d  = 32'd0;
                    read_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_WAIT_RELEASE: begin
                if (release_edge_q) begin
                    read_valid_d = 1'b1;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                // The CPU advances on this edge, so never re-enter on a lingering IORead.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            read_data_q    <= 32'd0;
            read_valid_q   <= 1'b0;
            output_q       <= 32'd0;
            output_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_data_q    <= read_data_d;
            read_valid_q   <= read_valid_d;
            output_q       <= output_d;
            output_valid_q <= output_valid_d;
        end
    end

    // Combinational so the CPU freezes in the very cycle the read request appears.
    assign Stall = ~Reset & (((state_q == S_IDLE) & IORead) |
                             (state_q == S_WAIT_PRESS) |
                             (state_q == S_WAIT_RELEASE));

    assign Waiting     = (state_q == S_WAIT_PRESS);
    assign ReadData    = read_data_q;
    assign ReadValid   = read_valid_q;
    assign Output      = output_q;
    assign OutputValid = output_valid_q;

endmodule

// File: tb/tb_io_input_controller.sv
// Purpose : directed self-checking bench for io_input_controller.
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: models the CPU holding IORead until the ReadValid cycle.

module tb_io_input_controller;

    logic        Clock;
    logic        Reset;
    logic        IORead;
    logic        IOWrite;
    logic [31:0] WriteData;
    logic [12:0] Switches;
    logic        SetN;
    logic        Stall;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic [31:0] Output;
    logic        OutputValid;
    logic        Waiting;
    logic        TimedOut;

    int n_assert = 0;
    int n_fail   = 0;

    io_input_controller #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .IORead     (IORead),
        .IOWrite    (IOWrite),
        .WriteData  (WriteData),
        .Switches   (Switches),
        .SetN       (SetN),
        .Stall      (Stall),
        .ReadData   (ReadData),
        .ReadValid  (ReadValid),
        .Output     (Output),
        .OutputValid(OutputValid),
        .Waiting    (Waiting),
        .TimedOut   (TimedOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until ReadValid is seen (bounded); reports the tick count and
    // whether Stall stayed high on every cycle before the pulse.
    task automatic wait_rv(input int max, output int n, output logic stall_ok);
        n        = 0;
        stall_ok = 1'b1;
        do begin
            tick();
            n++;
            if (!ReadValid && !Stall) stall_ok = 1'b0;
        end while (!ReadValid && n < max);
    endtask

    // Ticks a fixed number of cycles, flagging any ReadValid/TimedOut seen.
    task automatic run(input int cycles, output logic rv_seen, output logic tmo_seen);
        rv_seen  = 1'b0;
        tmo_seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (ReadValid) rv_seen = 1'b1;
            if (TimedOut)  tmo_seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic stall_ok, rv_seen, tmo_seen;

        Reset = 1'b1; IORead = 1'b1; IOWrite = 1'b0; WriteData = 32'd0;
        Switches = 13'h0; SetN = 1'b1;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_stall_forced", {31'd0, Stall}, 32'd0);
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_output", Output, 32'd0);
        chk("rst_flags", {28'd0, ReadValid, OutputValid, TimedOut, Waiting}, 32'd0);
        IORead = 1'b0;
        Reset  = 1'b0;
        tick();

        // ---------------- output write ----------------
        IOWrite = 1'b1; WriteData = 32'hDEADBEEF;
        #1;
        chk("wr_no_stall", {31'd0, Stall}, 32'd0);
        tick();
        IOWrite = 1'b0;
        chk("wr_output", Output, 32'hDEADBEEF);
        chk("wr_output_valid", {31'd0, OutputValid}, 32'd1);

        // ---------------- capture 13'h1A5 ----------------
        Switches = 13'h1A5; IORead = 1'b1;
        #1;
        chk("cap_stall_same_cycle", {31'd0, Stall}, 32'd1);
        tick();
        chk("cap_waiting", {31'd0, Waiting}, 32'd1);
        SetN = 1'b0;
        run(10, rv_seen, tmo_seen);
        chk("cap_stall_while_pressed", {31'd0, Stall}, 32'd1);
        chk("cap_captured_early", ReadData, 32'h000001A5);
        SetN = 1'b1;
        wait_rv(40, lat, stall_ok);
        chk("cap_release_latency", lat, 32'd7);
        chk("cap_stall_held", {31'd0, stall_ok}, 32'd1);
        chk("cap_done_stall_low", {31'd0, Stall}, 32'd0);
        chk("cap_readdata", ReadData, 32'h000001A5);
        IORead = 1'b0;
        tick();
        chk("cap_rv_one_cycle", {31'd0, ReadValid}, 32'd0);
        chk("cap_back_idle", {30'd0, Stall, Waiting}, 32'd0);

`ifndef IO_TIMEOUT_EN
        // ---------------- glitch rejection + write ignored ----------------
        IORead = 1'b1;
        tick();
        SetN = 1'b0;
        tick(); tick();
        SetN = 1'b1;
        run(15, rv_seen, tmo_seen);
        chk("glitch_no_rv", {31'd0, rv_seen}, 32'd0);
        chk("glitch_waiting", {30'd0, Waiting, Stall}, 32'd3);
        IOWrite = 1'b1; WriteData = 32'h1;
        tick();
        IOWrite = 1'b0;
        chk("wr_ignored_busy", Output, 32'hDEADBEEF);
        Switches = 13'h0A5A;
        SetN = 1'b0;
        run(10, rv_seen, tmo_seen);
        SetN = 1'b1;
        wait_rv(40, lat, stall_ok);
        chk("glitch_then_press_lat", lat, 32'd7);
        chk("glitch_then_press_data", ReadData, 32'h00000A5A);
        IORead = 1'b0;
        tick();

        // ---------------- held button ----------------
        SetN = 1'b0;
        run(10, rv_seen, tmo_seen);
        IORead = 1'b1;
        run(20, rv_seen, tmo_seen);
        chk("held_no_rv", {31'd0, rv_seen}, 32'd0);
        chk("held_waiting", {31'd0, Waiting}, 32'd1);
        chk("held_readdata_kept", ReadData, 32'h00000A5A);
        Switches = 13'h0007;
        SetN = 1'b1;
        run(10, rv_seen, tmo_seen);
        chk("held_release_only", {30'd0, rv_seen, Waiting}, 32'd1);
        chk("no_timeout_pulse", {31'd0, tmo_seen}, 32'd0);
        SetN = 1'b0;
        run(10, rv_seen, tmo_seen);
        SetN = 1'b1;
        wait_rv(40, lat, stall_ok);
        chk("held_fresh_lat", lat, 32'd7);
        chk("held_readdata", ReadData, 32'h00000007);
        IORead = 1'b0;
        tick();
`else
        // ---------------- timeout ----------------
        IORead = 1'b1;
        tick();
        wait_rv(40, lat, stall_ok);
        chk("tmo_latency", lat, 32'd20);
        chk("tmo_pulses", {30'd0, TimedOut, ReadValid}, 32'd3);
        chk("tmo_readdata", ReadData, 32'd0);
        chk("tmo_stall_low", {31'd0, Stall}, 32'd0);
        IORead = 1'b0;
        tick();
        chk("tmo_one_cycle", {30'd0, TimedOut, ReadValid}, 32'd0);
`endif

        // ---------------- reset in WAIT_RELEASE ----------------
        Switches = 13'h1FFF; IORead = 1'b1;
        tick();
        SetN = 1'b0;
        run(10, rv_seen, tmo_seen);
        chk("mid_captured", ReadData, 32'h00001FFF);
        chk("mid_wait_release", {30'd0, Stall, Waiting}, 32'd2);
        Reset = 1'b1;
        #1;
        chk("mid_async_stall", {31'd0, Stall}, 32'd0);
        chk("mid_async_readdata", ReadData, 32'd0);
        IORead = 1'b0; SetN = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        run(12, rv_seen, tmo_seen);
        chk("mid_no_rv", {31'd0, rv_seen}, 32'd0);
        chk("mid_idle", {30'd0, Stall, Waiting}, 32'd0);
        IORead = 1'b1;
        #1;
        chk("mid_idle_accepts", {31'd0, Stall}, 32'd1);
        IORead = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
